// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the slave response FSM state type.
// Reusable by any AHB-Lite slave in this codebase.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahbl_state_e;

  // Sizes wider than a word are flagged separately by the caller.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    case (size)
      HSIZE_HALF: return addr_lo[0];
      HSIZE_WORD: return addr_lo != 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_byte_strobe.sv
// Byte-lane strobe decode for a 32-bit AHB-Lite data bus.
// Illegal sizes produce an all-zero strobe.
module ahbl_byte_strobe
  import ahbl_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] size,
  output logic [3:0] strobe
);

  always_comb begin
    strobe = 4'b0000;
    case (size)
      HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
      HSIZE_HALF: strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: strobe = 4'b1111;
      default:    strobe = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM slave with configurable wait states and two-cycle ERROR response.
// Writes commit on the closing data-phase edge; reads are combinational from the array.
module ahbl_sram_slave
  import ahbl_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int W_ADDR      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [31:0]       ahbls_hwdata,
  output logic [31:0]       ahbls_hrdata
);

  localparam int AW = $clog2(4 * DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [W_ADDR:0] MEM_BYTES = (W_ADDR + 1)'(4 * DEPTH);

  ahbl_state_e state;
  logic [3:0]    wait_cnt;
  logic          d_valid;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [2:0]    d_size;

  logic [31:0] mem [DEPTH];

  logic       accept;
  logic       addr_err;
  logic       close_okay;
  logic       mem_we;
  logic [3:0] strobe;
  logic       unused_ok;

  // Handshake: an address phase is taken on a clock edge only when the bus
  // HREADY and our own HREADYOUT are both high and HTRANS is NONSEQ/SEQ; the
  // data phase it opens ends on the first later edge where HREADYOUT is high.
  assign accept = ahbls_hready && ahbls_htrans[1] && ahbls_hready_resp;

  // Full-width compare so high address bits can never alias into the array.
  assign addr_err = (ahbls_hsize > HSIZE_WORD)
                 || misaligned(ahbls_haddr[1:0], ahbls_hsize)
                 || ({1'b0, ahbls_haddr} >= MEM_BYTES);

  assign close_okay = (state == ST_IDLE) && d_valid;
  assign mem_we     = rst_n && close_okay && d_write;

  assign unused_ok = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0]};

  ahbl_byte_strobe u_strobe (
    .addr_lo (d_addr[1:0]),
    .size    (d_size),
    .strobe  (strobe)
  );

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && strobe[b]) begin
        mem[d_addr[AW-1:2]][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
      end
    end
  end

  assign ahbls_hrdata = (close_okay && !d_write) ? mem[d_addr[AW-1:2]] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      wait_cnt          <= 4'd0;
      d_valid           <= 1'b0;
      d_write           <= 1'b0;
      d_addr            <= '0;
      d_size            <= 3'd0;
      ahbls_hready_resp <= 1'b1;
      ahbls_hresp       <= 1'b0;
    end else begin
      if (accept) begin
        d_addr  <= ahbls_haddr[AW-1:0];
        d_write <= ahbls_hwrite;
        d_size  <= ahbls_hsize;
      end
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (accept && addr_err) begin
            state             <= ST_ERR1;
            d_valid           <= 1'b0;
            ahbls_hready_resp <= 1'b0;
            ahbls_hresp       <= 1'b1;
          end else if (accept && (WAIT_STATES > 0)) begin
            state             <= ST_WAIT;
            wait_cnt          <= WAIT_LOAD;
            d_valid           <= 1'b1;
            ahbls_hready_resp <= 1'b0;
            ahbls_hresp       <= 1'b0;
          end else begin
            state             <= ST_IDLE;
            d_valid           <= accept;
            ahbls_hready_resp <= 1'b1;
            ahbls_hresp       <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state             <= ST_IDLE;
            ahbls_hready_resp <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state             <= ST_ERR2;
          ahbls_hready_resp <= 1'b1;
          ahbls_hresp       <= 1'b1;
        end
        default: begin
          state             <= ST_IDLE;
          d_valid           <= 1'b0;
          ahbls_hready_resp <= 1'b1;
          ahbls_hresp       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ahbl_sram_slave.md
AHBL_SRAM_SLAVE -- requirements
Module: ahbl_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra data-phase cycles per OKAY transfer; legal range 0..15.
REQ-003 SHALL have parameter W_ADDR, default 32, haddr width.
REQ-004 SHALL run from one clock; reset is synchronous and active-low.
REQ-005 SHALL have these ports, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- ahbls_hready_resp  out  1  this slave's HREADYOUT.
- ahbls_hready  in  1  bus HREADY.
- ahbls_hresp  out  1  1 = ERROR.
- ahbls_haddr  in  W_ADDR  address.
- ahbls_hwrite  in  1  write.
- ahbls_htrans  in  2  transfer type.
- ahbls_hsize  in  3  size.
- ahbls_hburst  in  3  ignored.
- ahbls_hprot  in  4  ignored.
- ahbls_hmastlock  in  1  ignored.
- ahbls_hwdata  in  32  write data.
- ahbls_hrdata  out  32  read data.

Function
REQ-006 SHALL accept an address phase only when ahbls_hready=1 and ahbls_htrans[1]=1 (NONSEQ/SEQ); it SHALL register haddr, hwrite and hsize on that edge.
REQ-007 SHALL answer IDLE/BUSY, or no accepted transfer, with zero-wait OKAY: hready_resp=1, hresp=0.
REQ-008 SHALL classify an accepted transfer as ERROR if any of these holds:
- hsize > 2;
- haddr is misaligned for hsize;
- haddr >= 4*DEPTH.
All other accepted transfers are OKAY.
REQ-009 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2.
REQ-010 FSM transitions from IDLE or from the final cycle of any response:
- OKAY accept with WAIT_STATES>0 -> WAIT;
- OKAY accept with WAIT_STATES=0 -> IDLE;
- ERROR accept -> ERR1;
- no accept -> IDLE.
REQ-011 WAIT SHALL load a down-counter with WAIT_STATES-1, drive hready_resp=0, and return to IDLE with hready_resp=1 the cycle after the counter reaches 0; an OKAY data phase is therefore exactly WAIT_STATES+1 cycles.
REQ-012 ERR1 SHALL drive hresp=1, hready_resp=0; ERR2 SHALL drive hresp=1, hready_resp=1 (two-cycle ERROR); the next state follows REQ-010.
REQ-013 While hready_resp=0, SHALL ignore the address phase (no new accept).
REQ-014 OKAY write: SHALL write memory only on the final data-phase cycle (hready_resp=1), using byte lanes decoded from the registered haddr[1:0] and hsize:
- byte: 1 lane;
- halfword: 2 lanes;
- word: 4 lanes.
REQ-015 OKAY read: SHALL present the full 32-bit word at the registered address on hrdata whenever hready_resp=1 closes the data phase; the master selects lanes.
REQ-016 hrdata SHALL be 0 in any cycle not closing an OKAY read; ERROR transfers SHALL never modify memory.
REQ-017 Back-to-back write then read of the same address SHALL return the newly written bytes, without a stall beyond WAIT_STATES.
REQ-018 Address bits above log2(4*DEPTH) SHALL be compared for ERROR only, never aliased.

Reset
REQ-019 On rst_n=0 at a clk edge:
- FSM -> IDLE; counter = 0;
- hready_resp=1, hresp=0, hrdata=0;
- registered address-phase state cleared.
REQ-020 Reset mid-WAIT or mid-ERR1 SHALL abandon the transfer with no memory write; memory contents are not reset.

Structure
REQ-021 SHALL place HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HSIZE encodings and the FSM state encoding in shared package ahbl_pkg.
REQ-022 Byte-lane strobe decode SHALL be one sub-module, ahbl_byte_strobe (haddr[1:0], hsize -> 4-bit strobe), reusable by other slaves.

Verification
REQ-023 WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 -> hready_resp=1 in every cycle, hrdata=0xDEADBEEF in the read data phase.
REQ-024 WAIT_STATES=3: read 0x20 -> hready_resp low for exactly 3 cycles, then high with hrdata = memory word.
REQ-025 Byte write 0xAA to 0x13 over word 0x11223344 -> subsequent read of 0x10 returns 0xAA223344.
REQ-026 Word access to 0x02, or access to 4*DEPTH -> hresp=1/hready_resp=0, then hresp=1/hready_resp=1; memory unchanged.
REQ-027 Drive rst_n=0 during cycle 2 of a WAIT_STATES=3 write -> outputs reach reset values next edge; target word unchanged.
REQ-028 Formal: bind ahbl_slave_assumptions-style assertions as checks on this slave; prove the ERROR sequence is always two cycles and OKAY latency equals WAIT_STATES+1.
